// File: rtl/axi_lite_demux_if.sv
// AXI-lite channel bundle: one AW/W/B/AR/R set with master and slave views.
// clk/rstn are interface ports so every instance shares the system clock and reset.
interface axi_lite_channel #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input logic clk,
   input logic rstn
);
   logic                      aw_valid;
   logic                      aw_ready;
   logic [ADDR_WIDTH-1:0]     aw_addr;
   logic [2:0]                aw_prot;
   logic                      w_valid;
   logic                      w_ready;
   logic [DATA_WIDTH-1:0]     w_data;
   logic [DATA_WIDTH/8-1:0]   w_strb;
   logic                      b_valid;
   logic                      b_ready;
   logic [1:0]                b_resp;
   logic                      ar_valid;
   logic                      ar_ready;
   logic [ADDR_WIDTH-1:0]     ar_addr;
   logic [2:0]                ar_prot;
   logic                      r_valid;
   logic                      r_ready;
   logic [DATA_WIDTH-1:0]     r_data;
   logic [1:0]                r_resp;

   modport master (
      input  clk, rstn,
      output aw_valid, aw_addr, aw_prot, input aw_ready,
      output w_valid, w_data, w_strb, input w_ready,
      input  b_valid, b_resp, output b_ready,
      output ar_valid, ar_addr, ar_prot, input ar_ready,
      input  r_valid, r_data, r_resp, output r_ready
   );

   modport slave (
      input  clk, rstn,
      input  aw_valid, aw_addr, aw_prot, output aw_ready,
      input  w_valid, w_data, w_strb, output w_ready,
      output b_valid, b_resp, input b_ready,
      input  ar_valid, ar_addr, ar_prot, output ar_ready,
      output r_valid, r_data, r_resp, input r_ready
   );
endinterface

// File: rtl/axi_lite_demux.sv
// AXI-lite 1-to-N address demultiplexer with a default port for unmatched addresses.
// Independent read and write FSMs, one outstanding transaction each.
module axi_lite_demux #(
   parameter int NUM_SLAVES = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLAVE_BASE = '0,
   parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLAVE_MASK = '0
) (
   input logic               clk,
   input logic               rstn,
   axi_lite_channel.slave    master,
   axi_lite_channel.master   slaves [NUM_SLAVES],
   axi_lite_channel.master   dflt
);
   // Downstream ports are flattened; index NUM_SLAVES is the default port.
   localparam int NP = NUM_SLAVES + 1;
   localparam int SW = DATA_WIDTH / 8;

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_AW = 2'd1, W_W = 2'd2, W_B = 2'd3} w_state_e;
   typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_R = 2'd2} r_state_e;

   w_state_e              w_state_r, w_state_s;
   r_state_e              r_state_r, r_state_s;
   logic [ADDR_WIDTH-1:0] aw_addr_r, ar_addr_r;
   logic [2:0]            aw_prot_r, ar_prot_r;
   logic [NP-1:0]         w_sel_r, r_sel_r;
   logic                  aw_cap_s, ar_cap_s;

   logic [NP-1:0]                 aw_valid_s, aw_ready_s, w_valid_s, w_ready_s;
   logic [NP-1:0]                 b_valid_s, b_ready_s, ar_valid_s, ar_ready_s;
   logic [NP-1:0]                 r_valid_s, r_ready_s;
   logic [NP-1:0][DATA_WIDTH-1:0] w_data_s, r_data_s;
   logic [NP-1:0][SW-1:0]         w_strb_s;
   logic [NP-1:0][1:0]            b_resp_s, r_resp_s;

   logic                  sel_aw_ready_s, sel_w_ready_s, sel_b_valid_s;
   logic                  sel_ar_ready_s, sel_r_valid_s;
   logic [1:0]            sel_b_resp_s, sel_r_resp_s;
   logic [DATA_WIDTH-1:0] sel_r_data_s;

   logic                  m_aw_ready_s, m_w_ready_s, m_b_valid_s;
   logic                  m_ar_ready_s, m_r_valid_s;
   logic [1:0]            m_b_resp_s, m_r_resp_s;
   logic [DATA_WIDTH-1:0] m_r_data_s;

   // One-hot decode: lowest matching window wins, no match selects the default port.
   function automatic logic [NP-1:0] decode(input logic [ADDR_WIDTH-1:0] addr);
      logic [NP-1:0] sel;
      logic          hit;
      sel = '0;
      hit = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (!hit && ((addr & SLAVE_MASK[i]) == SLAVE_BASE[i])) begin
            sel[i] = 1'b1;
            hit    = 1'b1;
         end
      end
      if (!hit) begin
         sel[NUM_SLAVES] = 1'b1;
      end
      return sel;
   endfunction

   for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_slv
      assign slaves[i].aw_valid = aw_valid_s[i];
      assign slaves[i].aw_addr  = aw_addr_r;
      assign slaves[i].aw_prot  = aw_prot_r;
      assign slaves[i].w_valid  = w_valid_s[i];
      assign slaves[i].w_data   = w_data_s[i];
      assign slaves[i].w_strb   = w_strb_s[i];
      assign slaves[i].b_ready  = b_ready_s[i];
      assign slaves[i].ar_valid = ar_valid_s[i];
      assign slaves[i].ar_addr  = ar_addr_r;
      assign slaves[i].ar_prot  = ar_prot_r;
      assign slaves[i].r_ready  = r_ready_s[i];
      assign aw_ready_s[i]      = slaves[i].aw_ready;
      assign w_ready_s[i]       = slaves[i].w_ready;
      assign b_valid_s[i]       = slaves[i].b_valid;
      assign b_resp_s[i]        = slaves[i].b_resp;
      assign ar_ready_s[i]      = slaves[i].ar_ready;
      assign r_valid_s[i]       = slaves[i].r_valid;
      assign r_data_s[i]        = slaves[i].r_data;
      assign r_resp_s[i]        = slaves[i].r_resp;
   end

   assign dflt.aw_valid          = aw_valid_s[NUM_SLAVES];
   assign dflt.aw_addr           = aw_addr_r;
   assign dflt.aw_prot           = aw_prot_r;
   assign dflt.w_valid           = w_valid_s[NUM_SLAVES];
   assign dflt.w_data            = w_data_s[NUM_SLAVES];
   assign dflt.w_strb            = w_strb_s[NUM_SLAVES];
   assign dflt.b_ready           = b_ready_s[NUM_SLAVES];
   assign dflt.ar_valid          = ar_valid_s[NUM_SLAVES];
   assign dflt.ar_addr           = ar_addr_r;
   assign dflt.ar_prot           = ar_prot_r;
   assign dflt.r_ready           = r_ready_s[NUM_SLAVES];
   assign aw_ready_s[NUM_SLAVES] = dflt.aw_ready;
   assign w_ready_s[NUM_SLAVES]  = dflt.w_ready;
   assign b_valid_s[NUM_SLAVES]  = dflt.b_valid;
   assign b_resp_s[NUM_SLAVES]   = dflt.b_resp;
   assign ar_ready_s[NUM_SLAVES] = dflt.ar_ready;
   assign r_valid_s[NUM_SLAVES]  = dflt.r_valid;
   assign r_data_s[NUM_SLAVES]   = dflt.r_data;
   assign r_resp_s[NUM_SLAVES]   = dflt.r_resp;

   assign master.aw_ready = m_aw_ready_s;
   assign master.w_ready  = m_w_ready_s;
   assign master.b_valid  = m_b_valid_s;
   assign master.b_resp   = m_b_resp_s;
   assign master.ar_ready = m_ar_ready_s;
   assign master.r_valid  = m_r_valid_s;
   assign master.r_data   = m_r_data_s;
   assign master.r_resp   = m_r_resp_s;

   assign sel_aw_ready_s = |(aw_ready_s & w_sel_r);
   assign sel_w_ready_s  = |(w_ready_s & w_sel_r);
   assign sel_b_valid_s  = |(b_valid_s & w_sel_r);
   assign sel_ar_ready_s = |(ar_ready_s & r_sel_r);
   assign sel_r_valid_s  = |(r_valid_s & r_sel_r);

   // AND-OR return muxes over the one-hot selects.
   always_comb begin
      sel_b_resp_s = 2'b00;
      sel_r_resp_s = 2'b00;
      sel_r_data_s = '0;
      for (int i = 0; i < NP; i++) begin
         sel_b_resp_s = sel_b_resp_s | (b_resp_s[i] & {2{w_sel_r[i]}});
         sel_r_resp_s = sel_r_resp_s | (r_resp_s[i] & {2{r_sel_r[i]}});
         sel_r_data_s = sel_r_data_s | (r_data_s[i] & {DATA_WIDTH{r_sel_r[i]}});
      end
   end

   // State and captured request registers for both paths.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         w_state_r <= W_IDLE;
         r_state_r <= R_IDLE;
         aw_addr_r <= '0;
         aw_prot_r <= 3'b000;
         w_sel_r   <= '0;
         ar_addr_r <= '0;
         ar_prot_r <= 3'b000;
         r_sel_r   <= '0;
      end else begin
         w_state_r <= w_state_s;
         r_state_r <= r_state_s;
         if (aw_cap_s) begin
            aw_addr_r <= master.aw_addr;
            aw_prot_r <= master.aw_prot;
            w_sel_r   <= decode(master.aw_addr);
         end
         if (ar_cap_s) begin
            ar_addr_r <= master.ar_addr;
            ar_prot_r <= master.ar_prot;
            r_sel_r   <= decode(master.ar_addr);
         end
      end
   end

   // Write FSM next state and per-phase routing; W and B pass through only in their phase.
   always_comb begin
      w_state_s    = w_state_r;
      aw_cap_s     = 1'b0;
      m_aw_ready_s = 1'b0;
      m_w_ready_s  = 1'b0;
      m_b_valid_s  = 1'b0;
      m_b_resp_s   = 2'b00;
      aw_valid_s   = '0;
      w_valid_s    = '0;
      w_data_s     = '0;
      w_strb_s     = '0;
      b_ready_s    = '0;
      case (w_state_r)
         W_IDLE: begin
            m_aw_ready_s = 1'b1;
            if (master.aw_valid) begin
               aw_cap_s  = 1'b1;
               w_state_s = W_AW;
            end else begin
               w_state_s = W_IDLE;
            end
         end
         W_AW: begin
            aw_valid_s = w_sel_r;
            if (sel_aw_ready_s) begin
               w_state_s = W_W;
            end else begin
               w_state_s = W_AW;
            end
         end
         W_W: begin
            w_valid_s   = w_sel_r & {NP{master.w_valid}};
            m_w_ready_s = sel_w_ready_s;
            for (int i = 0; i < NP; i++) begin
               w_data_s[i] = master.w_data & {DATA_WIDTH{w_sel_r[i]}};
               w_strb_s[i] = master.w_strb & {SW{w_sel_r[i]}};
            end
            if (master.w_valid && sel_w_ready_s) begin
               w_state_s = W_B;
            end else begin
               w_state_s = W_W;
            end
         end
         W_B: begin
            m_b_valid_s = sel_b_valid_s;
            m_b_resp_s  = sel_b_resp_s;
            b_ready_s   = w_sel_r & {NP{master.b_ready}};
            if (sel_b_valid_s && master.b_ready) begin
               w_state_s = W_IDLE;
            end else begin
               w_state_s = W_B;
            end
         end
         default: begin
            w_state_s = W_IDLE;
         end
      endcase
   end

   // Read FSM next state and per-phase routing; R passes through only in R_R.
   always_comb begin
      r_state_s    = r_state_r;
      ar_cap_s     = 1'b0;
      m_ar_ready_s = 1'b0;
      m_r_valid_s  = 1'b0;
      m_r_data_s   = '0;
      m_r_resp_s   = 2'b00;
      ar_valid_s   = '0;
      r_ready_s    = '0;
      case (r_state_r)
         R_IDLE: begin
            m_ar_ready_s = 1'b1;
            if (master.ar_valid) begin
               ar_cap_s  = 1'b1;
               r_state_s = R_AR;
            end else begin
               r_state_s = R_IDLE;
            end
         end
         R_AR: begin
            ar_valid_s = r_sel_r;
            if (sel_ar_ready_s) begin
               r_state_s = R_R;
            end else begin
               r_state_s = R_AR;
            end
         end
         R_R: begin
            m_r_valid_s = sel_r_valid_s;
            m_r_data_s  = sel_r_data_s;
            m_r_resp_s  = sel_r_resp_s;
            r_ready_s   = r_sel_r & {NP{master.r_ready}};
            if (sel_r_valid_s && master.r_ready) begin
               r_state_s = R_IDLE;
            end else begin
               r_state_s = R_R;
            end
         end
         default: begin
            r_state_s = R_IDLE;
         end
      endcase
   end
endmodule
